eaf_hash_pipe: RTL and testbench

Pipelined, parametrised hash-index generator for the EAF Bloom filter. It replaces the single-shot combinational hash with a three-stage valid/ready pipeline. Each accepted address produces NUM_HASH independent array indices by double hashing over a two-round multiply-xorshift mix. It sits between the cache request path and the Bloom filter bit-array controller, and forwards an op bit and a tag with each request so insert and test traffic can share one unit.

---
 rtl/eaf_hash_pipe.sv | 164 ++++++++++++++++
 tb/tb_eaf_hash_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eaf_hash_pipe.sv
// eaf_hash_pipe -- three-stage valid/ready hash-index generator for the EAF
// Bloom filter. Each accepted address yields NUM_HASH array indices by double
// hashing (hA + i*hB) over a two-round multiply-xorshift mix of addr ^ seed.
//
// Optional feature macro: EAF_HASH_SEED_EN (adds seed_we/seed_i and a seed
// register; without it the seed is constant 0).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake; addr_i, op_i, tag_i request payload
//   seed_we, seed_i      seed register write (EAF_HASH_SEED_EN only)
//   out_valid/out_ready  result handshake; idx_o (index i at [i*IDX_W +: IDX_W]),
//                        op_o, tag_o result payload
//
// One register per stage (m1, m2, idx): a request presented in the cycle after
// edge t is taken at edge t+1 and is visible on the outputs after edge t+3.

// Per-lane index: hA + LANE*hB, wrapping at IDX_W bits.
module eaf_hash_lane #(
  parameter int IDX_W = 13,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] i_ha,
  input  logic [IDX_W-1:0] i_hb,
  output logic [IDX_W-1:0] o_idx
);
  assign o_idx = i_ha + IDX_W'(LANE) * i_hb;
endmodule

module eaf_hash_pipe #(
  parameter int          ADDR_W   = 32,
  parameter int          NUM_HASH = 7,
  parameter int          IDX_W    = 13,
  parameter int          TAG_W    = 4,
  parameter logic [31:0] C1       = 32'h55555555,
  parameter logic [31:0] C2       = 32'h9e3779b9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic                      op_i,
  input  logic [TAG_W-1:0]          tag_i,
`ifdef EAF_HASH_SEED_EN
  input  logic                      seed_we,
  input  logic [ADDR_W-1:0]         seed_i,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_HASH*IDX_W-1:0] idx_o,
  output logic                      op_o,
  output logic [TAG_W-1:0]          tag_o
);
  localparam int              H  = ADDR_W / 2;
  localparam logic [ADDR_W-1:0] K1 = ADDR_W'(C1);
  localparam logic [ADDR_W-1:0] K2 = ADDR_W'(C2);

  logic [ADDR_W-1:0] w_seed;

`ifdef EAF_HASH_SEED_EN
  logic [ADDR_W-1:0] r_seed;

  // Stage 1 reads r_seed before this edge's write lands, so a request taken
  // on the write edge still hashes with the old seed.
  always_ff @(posedge clk) begin
    if (rst)          r_seed <= '0;
    else if (seed_we) r_seed <= seed_i;
  end
  assign w_seed = r_seed;
`else
  assign w_seed = '0;
`endif

  // Stage valids and ready chain; ready ripples combinationally from out_ready.
  logic [3:1] r_vld_pipe;
  logic [4:1] w_rdy;

  always_comb begin
    w_rdy    = '0;
    w_rdy[4] = out_ready;
    for (int n = 3; n >= 1; n--) w_rdy[n] = !r_vld_pipe[n] || w_rdy[n+1];
  end

  assign in_ready = w_rdy[1];

  logic w_ld1, w_ld2, w_ld3;
  assign w_ld1 = in_valid      && w_rdy[1];
  assign w_ld2 = r_vld_pipe[1] && w_rdy[2];
  assign w_ld3 = r_vld_pipe[2] && w_rdy[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_rdy[1]) r_vld_pipe[1] <= in_valid;
      if (w_rdy[2]) r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_rdy[3]) r_vld_pipe[3] <= r_vld_pipe[2];
    end
  end

  // Hash datapath
  logic [ADDR_W-1:0] w_x, w_mix1, w_mix2;
  logic [ADDR_W-1:0] r_m1, r_m2;
  logic              r_op1, r_op2, r_op3;
  logic [TAG_W-1:0]  r_tag1, r_tag2, r_tag3;

  assign w_x    = addr_i ^ w_seed;
  assign w_mix1 = w_x  ^ (w_x  >> H);
  assign w_mix2 = r_m1 ^ (r_m1 >> H);

  logic [IDX_W-1:0] w_ha, w_hb;
  assign w_ha = r_m2[IDX_W-1:0];
  // Odd step is coprime with 2^IDX_W, so the k indices never collide.
  assign w_hb = r_m2[ADDR_W-1 -: IDX_W] | IDX_W'(1);

  logic [NUM_HASH-1:0][IDX_W-1:0] w_idx, r_idx;

  for (genvar g = 0; g < NUM_HASH; g++) begin : g_lane
    eaf_hash_lane #(.IDX_W(IDX_W), .LANE(g)) u_lane (
      .i_ha  (w_ha),
      .i_hb  (w_hb),
      .o_idx (w_idx[g])
    );
  end

  // Data registers load only on a transfer into the stage; a stalled stage
  // keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m1   <= '0;
      r_op1  <= 1'b0;
      r_tag1 <= '0;
      r_m2   <= '0;
      r_op2  <= 1'b0;
      r_tag2 <= '0;
      r_idx  <= '0;
      r_op3  <= 1'b0;
      r_tag3 <= '0;
    end else begin
      if (w_ld1) begin
        r_m1   <= w_mix1 * K1;
        r_op1  <= op_i;
        r_tag1 <= tag_i;
      end
      if (w_ld2) begin
        r_m2   <= w_mix2 * K2;
        r_op2  <= r_op1;
        r_tag2 <= r_tag1;
      end
      if (w_ld3) begin
        r_idx  <= w_idx;
        r_op3  <= r_op2;
        r_tag3 <= r_tag2;
      end
    end
  end

  assign out_valid = r_vld_pipe[3];
  assign idx_o     = r_idx;
  assign op_o      = r_op3;
  assign tag_o     = r_tag3;

endmodule

// File: tb/tb_eaf_hash_pipe.sv
// Directed bench for eaf_hash_pipe (default parameters). Expected index
// vectors for addresses 0..3 are hand-derived from the hash definition.
// Seed tests are built only with EAF_HASH_SEED_EN.
module tb_eaf_hash_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr_i;
  logic        op_i;
  logic [3:0]  tag_i;
  logic        out_valid;
  logic        out_ready;
  logic [90:0] idx_o;
  logic        op_o;
  logic [3:0]  tag_o;
`ifdef EAF_HASH_SEED_EN
  logic        seed_we;
  logic [31:0] seed_i;
  logic [31:0] m_seed;
`endif

  always #5 clk = ~clk;

  eaf_hash_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr_i    (addr_i),
    .op_i      (op_i),
    .tag_i     (tag_i),
`ifdef EAF_HASH_SEED_EN
    .seed_we   (seed_we),
    .seed_i    (seed_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx_o     (idx_o),
    .op_o      (op_o),
    .tag_o     (tag_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-computed indices (C1=0x55555555, C2=0x9e3779b9, seed 0):
  //   a=0: m2=0          hA=0 hB=0x0001
  //   a=1: m2=0xD76D0000 hA=0 hB=0x1AED
  //   a=2: m2=0xAEDA0000 hA=0 hB=0x15DB
  //   a=3: m2=0x86470000 hA=0 hB=0x10C9
  function automatic logic [90:0] exp_idx(input logic [31:0] a);
    logic [12:0] t[7];
    logic [90:0] r;
    case (a)
      32'd0:   t = '{13'h0000, 13'h0001, 13'h0002, 13'h0003, 13'h0004, 13'h0005, 13'h0006};
      32'd1:   t = '{13'h0000, 13'h1AED, 13'h15DA, 13'h10C7, 13'h0BB4, 13'h06A1, 13'h018E};
      32'd2:   t = '{13'h0000, 13'h15DB, 13'h0BB6, 13'h0191, 13'h176C, 13'h0D47, 13'h0322};
      32'd3:   t = '{13'h0000, 13'h10C9, 13'h0192, 13'h125B, 13'h0324, 13'h13ED, 13'h04B6};
      default: t = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
    endcase
    r = '0;
    for (int i = 0; i < 7; i++) r[i*13 +: 13] = t[i];
    return r;
  endfunction

  typedef struct {
    logic [90:0] idx;
    logic        op;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];

  // Scoreboard: inputs change only just after posedge, so values seen at the
  // negedge are the ones the next posedge acts on.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] key;
    if (rst) begin
`ifdef EAF_HASH_SEED_EN
      m_seed = '0;
`endif
    end else if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {1'b1, tag_o}, 5'h0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_idx", idx_o, e.idx);
          chk("sb_op",  op_o,  e.op);
          chk("sb_tag", tag_o, e.tag);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        key = addr_i;
`ifdef EAF_HASH_SEED_EN
        key = addr_i ^ m_seed;
`endif
        e.idx = exp_idx(key);
        e.op  = op_i;
        e.tag = tag_i;
        exp_q.push_back(e);
      end
`ifdef EAF_HASH_SEED_EN
      if (seed_we) m_seed = seed_i;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single request with latency check: presented after edge E0, taken at E1,
  // visible after E3.
  task automatic single(input logic [31:0] a, input logic o, input logic [3:0] t);
    step();
    in_valid = 1'b1; addr_i = a; op_i = o; tag_i = t; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("lat_e1_vld", out_valid, 1'b0);
    @(negedge clk); chk("lat_e2_vld", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_e3_vld", out_valid, 1'b1);
    chk("lat_idx",    idx_o,     exp_idx(a));
    chk("lat_op",     op_o,      o);
    chk("lat_tag",    tag_o,     t);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; addr_i = '0; op_i = 1'b0; tag_i = '0; out_ready = 1'b1;
`ifdef EAF_HASH_SEED_EN
    seed_we = 1'b0; seed_i = '0; m_seed = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld",   out_valid, 1'b0);
    chk("rst_idx",   idx_o,     91'h0);
    chk("rst_op",    op_o,      1'b0);
    chk("rst_tag",   tag_o,     4'h0);
    chk("rst_rdy",   in_ready,  1'b1);

    // Directed single requests
    single(32'd0, 1'b0, 4'd3);
    single(32'd1, 1'b1, 4'd5);
    step();

    // Back-to-back stream, one accept per cycle
    mon_en = 1'b1;
    base   = n_out;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; addr_i = 32'(i % 4); op_i = i[0]; tag_i = 4'(i);
      @(negedge clk);
      chk("stream_rdy", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("stream_cnt", n_out - base, 8);
    chk("stream_q",   exp_q.size(), 0);

    // Stall with out_ready low: three held, fourth blocked
    base = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; addr_i = 32'(3 - i); op_i = 1'b1; tag_i = 4'(8 + i);
      step();
    end
    addr_i = 32'd0; op_i = 1'b0; tag_i = 4'd11;
    @(negedge clk);
    chk("stall_rdy", in_ready,  1'b0);
    chk("stall_vld", out_valid, 1'b1);
    chk("stall_idx", idx_o,     exp_idx(32'd3));
    chk("stall_tag", tag_o,     4'd8);
    repeat (3) step();
    @(negedge clk);
    chk("hold_rdy", in_ready, 1'b0);
    chk("hold_idx", idx_o,    exp_idx(32'd3));
    chk("hold_tag", tag_o,    4'd8);
    chk("hold_op",  op_o,     1'b1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pass_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("stall_cnt", n_out - base, 4);
    chk("stall_q",   exp_q.size(), 0);

`ifdef EAF_HASH_SEED_EN
    // Seed write on the accept edge: that request keeps the old seed
    base = n_out;
    seed_we = 1'b1; seed_i = 32'd1;
    in_valid = 1'b1; addr_i = 32'd0; op_i = 1'b0; tag_i = 4'd1;
    step();
    seed_we = 1'b0;
    addr_i = 32'd0; tag_i = 4'd2;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("seed_cnt", n_out - base, 2);
    chk("seed_q",   exp_q.size(), 0);
`endif

    // Reset with the pipeline full discards everything in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; addr_i = 32'(i + 1); op_i = 1'b1; tag_i = 4'(12 + i);
      step();
    end
    in_valid = 1'b0;
    base = n_out;
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_vld", out_valid, 1'b0);
    chk("mrst_idx", idx_o,     91'h0);
    chk("mrst_op",  op_o,      1'b0);
    chk("mrst_tag", tag_o,     4'h0);
    chk("mrst_rdy", in_ready,  1'b1);
    out_ready = 1'b1;
    repeat (6) step();
    chk("mrst_none", n_out - base, 0);

    // Post-reset request (seed back to 0 when the seed feature is built)
    in_valid = 1'b1; addr_i = 32'd1; op_i = 1'b0; tag_i = 4'd6;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("post_cnt", n_out - base, 1);
    chk("post_q",   exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
